fetch_stage: RTL and testbench

//  Instruction-fetch front end for the RV32I core, directly upstream of decode/execute.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_fifo.sv | 58 +++++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the RV32I instruction-fetch front end.
package fetch_stage_pkg;

    localparam int unsigned WORD_LEN_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam int unsigned DEPTH_DEF    = 4;

    // RUN delivers responses; FLUSH discards responses issued before a redirect.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_fifo.sv
// Registered synchronous FIFO with clear; clear has priority over push and pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !clear_i && full_o && !pop_i));

endmodule

// File: rtl/fetch_stage.sv
// Fetch PC, credit-based request issue, in-order response capture and redirect flush.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned         WORD_LEN = WORD_LEN_DEF,
    parameter logic [WORD_LEN-1:0] RESET_PC = WORD_LEN'(RESET_PC_DEF),
    parameter int unsigned         DEPTH    = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [WORD_LEN-1:0] req_addr,
    input  logic                resp_valid,
    input  logic [WORD_LEN-1:0] resp_inst,
    input  logic                redirect_valid,
    input  logic [WORD_LEN-1:0] redirect_pc,
    input  logic                halt,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [WORD_LEN-1:0] if_pc,
    output logic [WORD_LEN-1:0] if_inst
);

    localparam int unsigned         CW      = $clog2(DEPTH) + 1;
    localparam logic [WORD_LEN-1:0] PC_STEP = WORD_LEN'(4);

    logic [WORD_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_LEN-1:0] exp_pc_q, exp_pc_d;
    logic [CW-1:0]       out_q, out_d;
    logic [CW-1:0]       drop_q, drop_d;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         load;
    logic [WORD_LEN-1:0] redirect_tgt;
    logic                fifo_full, fifo_empty;
    logic                deq, issue, push;
    fetch_state_e        state;

    assign state        = (drop_q != '0) ? ST_FLUSH : ST_RUN;
    assign redirect_tgt = redirect_pc & ~WORD_LEN'(3);
    assign deq          = if_valid && if_ready;
    assign if_valid     = !fifo_empty;
    assign req_addr     = fetch_pc_q;

    // Credit counts both in-flight requests and buffered entries, so every response has a slot.
    assign load      = {1'b0, out_q} + {1'b0, fifo_count} - (CW + 1)'(deq);
    assign req_valid = rst_n && !halt && !redirect_valid && (load < (CW + 1)'(DEPTH));
    assign issue     = req_valid && req_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        exp_pc_d   = exp_pc_q;
        drop_d     = drop_q;
        push       = 1'b0;
        out_d      = out_q + CW'(issue) - CW'(resp_valid);
        if (issue) fetch_pc_d = fetch_pc_q + PC_STEP;
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            exp_pc_d   = redirect_tgt;
            drop_d     = out_d;
        end else if (resp_valid) begin
            if (state == ST_FLUSH) begin
                drop_d = drop_q - CW'(1);
            end else begin
                push     = 1'b1;
                exp_pc_d = exp_pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            exp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            exp_pc_q   <= exp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (2 * WORD_LEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (redirect_valid),
        .push_i  (push),
        .wdata_i ({exp_pc_q, resp_inst}),
        .pop_i   (deq),
        .rdata_o ({if_pc, if_inst}),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    a_full_consistent : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full |-> (out_q == '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a PC-stream reference model.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_inst;

    fetch_stage #(.WORD_LEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_inst      (resp_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // memory: in-order queue of accepted addresses and the cycle each may answer
    logic [31:0] mq_addr[$];
    int          mq_rdy[$];
    int          cyc, last_rdy, lat_lo, lat_hi, tb_out;
    // reference stream: next PC the core should see, next PC that should be requested
    logic [31:0] model_pc, iss_pc, first_pc;
    bit          exp_empty, seek_first;
    int          n_req, n_deliv, first_valid_cyc;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[17:2]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_ready = 0; if_ready = 0; redirect_valid = 0; redirect_pc = 0; halt = 0;
        resp_valid = 0; resp_inst = 0;
        mq_addr.delete(); mq_rdy.delete();
        tb_out = 0;
        @(negedge clk);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc = 0; last_rdy = -1;
        model_pc = 32'h0; iss_pc = 32'h0;
        exp_empty = 0; seek_first = 0; first_pc = 32'hDEAD_BEEF;
        n_req = 0; n_deliv = 0; first_valid_cyc = -1;
    endtask

    task automatic step(input bit rr, input bit ir, input bit red, input logic [31:0] tgt, input bit hlt);
        int rdy;
        if (mq_addr.size() > 0 && mq_rdy[0] <= cyc) begin
            resp_valid = 1'b1;
            resp_inst  = inst_of(mq_addr.pop_front());
            void'(mq_rdy.pop_front());
            tb_out--;
        end else begin
            resp_valid = 1'b0;
            resp_inst  = $urandom;
        end
        req_ready = rr; if_ready = ir; redirect_valid = red; redirect_pc = tgt; halt = hlt;
        @(negedge clk);
        if (exp_empty) chk("flush_empty", {31'b0, if_valid}, 32'd0);
        exp_empty = 0;
        if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (red) begin
            chk("redir_noreq", {31'b0, req_valid}, 32'd0);
            model_pc = tgt & ~32'd3;
            iss_pc   = tgt & ~32'd3;
            exp_empty = 1; seek_first = 1;
        end else begin
            if (hlt) chk("halt_noreq", {31'b0, req_valid}, 32'd0);
            if (if_valid && if_ready) begin
                chk("if_pc", if_pc, model_pc);
                chk("if_inst", if_inst, inst_of(model_pc));
                if (seek_first) begin first_pc = if_pc; seek_first = 0; end
                model_pc += 32'd4;
                n_deliv++;
            end
            if (req_valid && req_ready) begin
                chk("req_addr", req_addr, iss_pc);
                rdy = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (rdy <= last_rdy) rdy = last_rdy + 1;
                last_rdy = rdy;
                mq_addr.push_back(iss_pc); mq_rdy.push_back(rdy);
                iss_pc += 32'd4;
                tb_out++; n_req++;
            end
        end
        chk("outstanding_le_depth", {31'b0, tb_out <= 4}, 32'd1);
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        bit          hstate;
        logic [31:0] tgt;

        // 1: back-to-back fetch, first instruction two cycles after release
        lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);
        chk("t1_first_valid_cyc", first_valid_cyc, 32'd2);
        chk("t1_throughput", n_deliv, 32'd10);

        // 2: core stalls; credit caps requests at DEPTH
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
        chk("t2_req_count", n_req, 32'd4);
        chk("t2_req_valid_low", {31'b0, req_valid}, 32'd0);
        chk("t2_head_valid", {31'b0, if_valid}, 32'd1);
        chk("t2_head_pc", if_pc, 32'h0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
        chk("t2_drain", {31'b0, n_deliv >= 4}, 32'd1);

        // 3: redirect with two requests in flight on a 3-cycle memory
        lat_lo = 3; lat_hi = 3;
        do_reset();
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("t3_outstanding", tb_out, 32'd2);
        step(1, 1, 1, 32'h40, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);
        chk("t3_first_pc", first_pc, 32'h40);

        // 4: redirect coincides with a response and a pop
        lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 32'h200, 0);
        chk("t4_req_addr", req_addr, 32'h200);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);
        chk("t4_first_pc", first_pc, 32'h200);

        // 5: misaligned redirect target is word aligned
        step(1, 1, 1, 32'h103, 0);
        chk("t5_req_addr", req_addr, 32'h100);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);
        chk("t5_first_pc", first_pc, 32'h100);

        // 6: halt with two in flight still delivers both
        lat_lo = 3; lat_hi = 3;
        do_reset();
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 1);
        chk("t6_req_count", n_req, 32'd2);
        chk("t6_delivered", n_deliv, 32'd2);

        // wrap-around of the PC past the top of the address space
        lat_lo = 1; lat_hi = 2;
        do_reset();
        step(1, 1, 1, 32'hFFFF_FFF6, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
        chk("wrap_first_pc", first_pc, 32'hFFFF_FFF4);
        chk("wrap_model_pc", {31'b0, model_pc < 32'h100}, 32'd1);

        // randomized traffic: variable latency, stalls, redirects, halts
        lat_lo = 1; lat_hi = 4;
        do_reset();
        hstate = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99, 0) < 5) hstate = ~hstate;
            if ($urandom_range(99, 0) < 3) begin
                tgt = $urandom;
                if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
                step($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 70, 1, tgt, hstate);
            end else begin
                step($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 70, 0, 0, hstate);
            end
        end
        n_deliv = 0;
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 0);
        chk("rand_liveness", {31'b0, n_deliv >= 20}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
